// File: rtl/dpi_seq_pkg.sv
// Shared types and defaults for the DPI stream sequencer and its stream table.
package dpi_seq_pkg;

    localparam int N_REGEX_DEF   = 8;
    localparam int SID_W_DEF     = 6;
    localparam int MATCH_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP,
        ST_REPORT
    } seq_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream table: regex enable mask (cfg written) and seen bit (set on packet close, clear-all).
module dpi_stream_table
    import dpi_seq_pkg::*;
#(
    parameter int SID_W   = SID_W_DEF,
    parameter int N_REGEX = N_REGEX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [SID_W-1:0]   cfg_sid,
    input  logic [N_REGEX-1:0] cfg_mask,
    input  logic               seen_clr,
    input  logic               seen_set,
    input  logic [SID_W-1:0]   seen_sid,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [N_REGEX-1:0] rd_mask,
    output logic               rd_seen
);

    localparam int DEPTH = 1 << SID_W;

    logic [N_REGEX-1:0] mask_mem [DEPTH];
    logic [DEPTH-1:0]   written;
    logic [DEPTH-1:0]   seen;

    // NOTE: the mask storage is deliberately left without reset so it maps to plain RAM;
    // the small per-entry written vector is what makes unwritten entries read as zero.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mask_mem[cfg_sid] <= cfg_mask;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
            seen    <= '0;
        end else begin
            if (cfg_we) begin
                written[cfg_sid] <= 1'b1;
            end
            // Clear-all has priority over a same-cycle set.
            if (seen_clr) begin
                seen <= '0;
            end else if (seen_set) begin
                seen[seen_sid] <= 1'b1;
            end
        end
    end

    assign rd_mask = written[rd_sid] ? mask_mem[rd_sid] : '0;
    assign rd_seen = seen[rd_sid];

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Front-end controller for the per-regex stream matchers: load, stream, drain, eop, report.
// Optional statistics counters are built when DPI_SEQ_STATS_EN is defined.
module dpi_stream_sequencer
    import dpi_seq_pkg::*;
#(
    parameter int N_REGEX   = N_REGEX_DEF,
    parameter int SID_W     = SID_W_DEF,
    parameter int MATCH_LAT = MATCH_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_vld,
    output logic               pkt_rdy,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [7:0]         pkt_data,
    input  logic [SID_W-1:0]   pkt_sid,
    input  logic               cfg_we,
    input  logic [SID_W-1:0]   cfg_sid,
    input  logic [N_REGEX-1:0] cfg_mask,
    input  logic               cfg_clr_seen,
    output logic               load_state,
    output logic               new_stream_id,
    output logic [SID_W-1:0]   stream_id,
    output logic [7:0]         char_in,
    output logic               char_in_vld,
    output logic               eop,
    output logic [N_REGEX-1:0] enable,
    input  logic [N_REGEX-1:0] fired,
    output logic               res_vld,
    input  logic               res_rdy,
    output logic [SID_W-1:0]   res_sid,
    output logic [N_REGEX-1:0] res_fired,
    output logic [31:0]        stat_pkts,
    output logic [15:0]        stat_drops
);

    localparam int CNT_W = (MATCH_LAT < 2) ? 1 : $clog2(MATCH_LAT);

    seq_state_t         state;
    logic [7:0]         hold_data;
    logic               hold_eop;
    logic               cur_eop;
    logic [CNT_W-1:0]   drain_cnt;
    logic [N_REGEX-1:0] tbl_mask;
    logic               tbl_seen;
    logic               seen_set;
    logic               drop;

    assign seen_set = (state == ST_EOP);
    assign drop     = (state == ST_IDLE) && pkt_vld && pkt_rdy && !pkt_sop;

    // The table is read with the incoming sop sid, so LOAD always sees pre-write contents.
    dpi_stream_table #(
        .SID_W   (SID_W),
        .N_REGEX (N_REGEX)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_sid  (cfg_sid),
        .cfg_mask (cfg_mask),
        .seen_clr (cfg_clr_seen),
        .seen_set (seen_set),
        .seen_sid (stream_id),
        .rd_sid   (pkt_sid),
        .rd_mask  (tbl_mask),
        .rd_seen  (tbl_seen)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pkt_rdy       <= 1'b0;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            stream_id     <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            enable        <= '0;
            res_vld       <= 1'b0;
            res_sid       <= '0;
            res_fired     <= '0;
            hold_data     <= '0;
            hold_eop      <= 1'b0;
            cur_eop       <= 1'b0;
            drain_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pkt_rdy <= 1'b1;
                    if (pkt_vld && pkt_rdy && pkt_sop) begin
                        hold_data     <= pkt_data;
                        hold_eop      <= pkt_eop;
                        stream_id     <= pkt_sid;
                        enable        <= tbl_mask;
                        load_state    <= 1'b1;
                        new_stream_id <= ~tbl_seen;
                        pkt_rdy       <= 1'b0;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_state    <= 1'b0;
                    new_stream_id <= 1'b0;
                    state         <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    char_in     <= hold_data;
                    char_in_vld <= 1'b1;
                    cur_eop     <= hold_eop;
                    pkt_rdy     <= ~hold_eop;
                    state       <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Leave once the eop byte has been on char_in for its one cycle.
                    if (char_in_vld && cur_eop) begin
                        char_in_vld <= 1'b0;
                        drain_cnt   <= CNT_W'(MATCH_LAT - 1);
                        state       <= ST_DRAIN;
                    end else if (pkt_vld && pkt_rdy) begin
                        char_in     <= pkt_data;
                        char_in_vld <= 1'b1;
                        cur_eop     <= pkt_eop;
                        if (pkt_eop) begin
                            pkt_rdy <= 1'b0;
                        end
                    end else begin
                        char_in_vld <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        eop   <= 1'b1;
                        state <= ST_EOP;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                ST_EOP: begin
                    eop       <= 1'b0;
                    res_vld   <= 1'b1;
                    res_sid   <= stream_id;
                    res_fired <= fired & enable;
                    state     <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        pkt_rdy <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DPI_SEQ_STATS_EN
    logic [31:0] pkts_q;
    logic [15:0] drops_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkts_q  <= '0;
            drops_q <= '0;
        end else begin
            if (state == ST_REPORT && res_rdy) begin
                pkts_q <= pkts_q + 32'd1;
            end
            if (drop) begin
                drops_q <= sat_inc16(drops_q);
            end
        end
    end

    assign stat_pkts  = pkts_q;
    assign stat_drops = drops_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign stat_pkts   = '0;
    assign stat_drops  = '0;
`endif

endmodule
